// File: rtl/eq_serial_ctrl_pkg.sv
// Shared definitions for the serial equality sequencer.
// Holds the FSM state encoding and the pair-index width derivation.
package eq_serial_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Index width for WIDTH/2 pairs, never narrower than one bit.
  function automatic int idxw_f(input int width);
    int n_pairs;
    n_pairs = width / 32'sd2;
    if (n_pairs <= 32'sd1) begin
      return 32'sd1;
    end else begin
      return $clog2(n_pairs);
    end
  endfunction

endpackage

// File: rtl/eq_serial_ctrl_eq2_slice.sv
// Combinational 2-bit equality slice.
// The sequencer time-shares one instance across all bit-pairs.
module eq2_slice (
  input  logic [1:0] x,
  input  logic [1:0] y,
  output logic       eq
);

  assign eq = (x == y);

endmodule

// File: rtl/eq_serial_ctrl.sv
// Serial WIDTH-bit equality sequencer: one bit-pair per cycle, LSB pair first,
// start/busy/done handshake with early exit on the first mismatching pair.
module eq_serial_ctrl
  import eq_serial_ctrl_pkg::*;
#(
  parameter  int WIDTH = 8,
  localparam int IDXW  = idxw_f(WIDTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             aeqb,
  output logic [IDXW-1:0]  mismatch_idx
);

  localparam int              NPAIR    = WIDTH / 2;
  localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NPAIR - 1);

  state_t           r_state;
  logic [WIDTH-1:0] r_sa;
  logic [WIDTH-1:0] r_sb;
  logic [IDXW-1:0]  r_cnt;
  logic             r_busy;
  logic             r_done;
  logic             r_aeqb;
  logic [IDXW-1:0]  r_idx;

  state_t           w_state_nxt;
  logic [WIDTH-1:0] w_sa_nxt;
  logic [WIDTH-1:0] w_sb_nxt;
  logic [IDXW-1:0]  w_cnt_nxt;
  logic             w_aeqb_nxt;
  logic [IDXW-1:0]  w_idx_nxt;
  logic             w_pair_eq;

  eq2_slice u_slice (
    .x  (r_sa[1:0]),
    .y  (r_sb[1:0]),
    .eq (w_pair_eq)
  );

  // Next-state and datapath update logic.
  always_comb begin
    w_state_nxt = r_state;
    w_sa_nxt    = r_sa;
    w_sb_nxt    = r_sb;
    w_cnt_nxt   = r_cnt;
    w_aeqb_nxt  = r_aeqb;
    w_idx_nxt   = r_idx;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_sa_nxt    = a;
          w_sb_nxt    = b;
          w_cnt_nxt   = {IDXW{1'b0}};
          w_aeqb_nxt  = 1'b0;
          w_idx_nxt   = {IDXW{1'b0}};
          w_state_nxt = ST_RUN;
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
      ST_RUN: begin
        if (!w_pair_eq) begin
          w_aeqb_nxt  = 1'b0;
          w_idx_nxt   = r_cnt;
          w_state_nxt = ST_DONE;
        end else if (r_cnt == LAST_IDX) begin
          w_aeqb_nxt  = 1'b1;
          w_idx_nxt   = {IDXW{1'b0}};
          w_state_nxt = ST_DONE;
        end else begin
          w_sa_nxt    = r_sa >> 2'd2;
          w_sb_nxt    = r_sb >> 2'd2;
          w_cnt_nxt   = r_cnt + {{(IDXW-1){1'b0}}, 1'b1};
          w_state_nxt = ST_RUN;
        end
      end
      ST_DONE: begin
        w_state_nxt = ST_IDLE;
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  // busy/done are registered from the next state so they never glitch.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= ST_IDLE;
      r_sa    <= {WIDTH{1'b0}};
      r_sb    <= {WIDTH{1'b0}};
      r_cnt   <= {IDXW{1'b0}};
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_aeqb  <= 1'b0;
      r_idx   <= {IDXW{1'b0}};
    end else begin
      r_state <= w_state_nxt;
      r_sa    <= w_sa_nxt;
      r_sb    <= w_sb_nxt;
      r_cnt   <= w_cnt_nxt;
      r_busy  <= (w_state_nxt == ST_RUN);
      r_done  <= (w_state_nxt == ST_DONE);
      r_aeqb  <= w_aeqb_nxt;
      r_idx   <= w_idx_nxt;
    end
  end

  assign busy         = r_busy;
  assign done         = r_done;
  assign aeqb         = r_aeqb;
  assign mismatch_idx = r_idx;

endmodule

// File: doc/eq_serial_ctrl.md
Name: eq_serial_ctrl

Overview:
Sequencer that decides whether two WIDTH-bit operands are equal. It time-shares a single 2-bit equality slice, comparing one bit-pair per cycle, LSB pair first. It uses a start/busy/done handshake and stops early on the first mismatching pair. It sits between a requesting controller and the small combinational equality datapath, so wide compares need only one 2-bit comparator.

Parameters:
WIDTH, 8, operand width in bits; must be even and >= 2; N = WIDTH/2 pairs.
IDXW, derived = max(1, clog2(WIDTH/2)), width of the pair-index counter and of mismatch_idx.

Ports:
clk  in  1  single clock; all state updates on rising edge
reset  in  1  asynchronous, active-high; clears all state immediately
start  in  1  request pulse; sampled only in IDLE
a  in  WIDTH  operand A; captured on the accepted start edge
b  in  WIDTH  operand B; captured on the accepted start edge
busy  out  1  high while in RUN
done  out  1  one-cycle pulse; high only while in DONE
aeqb  out  1  result: 1 = operands equal; valid from done, held until the next accepted start
mismatch_idx  out  IDXW  index of first mismatching pair; 0 when aeqb=1; held like aeqb

Behaviour:
- Reset (async, any state): state=IDLE; busy=0, done=0, aeqb=0, mismatch_idx=0; shift registers and counter = 0. A reset during RUN abandons the compare; no done is issued.
- States are IDLE, RUN and DONE. busy and done decode from state; both are glitch-free registered state bits.
- IDLE: if start=1 at the edge, load sa<=a, sb<=b, cnt<=0, clear aeqb and mismatch_idx, and go to RUN. Otherwise hold.
- RUN, each edge: the slice compares sa[1:0] against sb[1:0].
  - Pair mismatch: aeqb<=0, mismatch_idx<=cnt, go to DONE.
  - Pair match and cnt==N-1: aeqb<=1, mismatch_idx<=0, go to DONE.
  - Pair match otherwise: sa>>=2, sb>>=2, cnt<=cnt+1, stay in RUN.
- DONE: lasts exactly one cycle, then go to IDLE unconditionally.
- Latency, counting the start edge as edge 0:
  - First mismatch at pair p: done is high in the cycle after edge p+1.
  - Full match: done is high in the cycle after edge N.
  - Minimum start-to-start period is the compare latency plus 1.
- start is ignored in RUN and DONE; it is not queued. a and b are don't-care outside the accepted start edge.
- cnt never wraps; the cnt==N-1 check terminates RUN. For WIDTH=2 (N=1), RUN lasts exactly one cycle.
- Outputs are registered only; there is no combinational path from start, a or b to any output.

Decomposition:
- Shared package holds the state encoding constants (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the IDXW derivation function.
- One sub-module, eq2_slice: purely combinational 2-bit equality (inputs x[1:0] and y[1:0], output eq). It is instantiated once in eq_serial_ctrl.
- Everything else (FSM, shift registers, counter, result registers) lives in eq_serial_ctrl.

Test Plan (WIDTH=8, N=4):
1. Reset asserted mid-cycle, asynchronously, with no clock edge → all outputs 0 immediately. Release reset, then start with a=8'hA5, b=8'hA5 → busy for 4 cycles, done pulse one cycle later, aeqb=1, mismatch_idx=0.
2. a=8'hA5, b=8'hA4 → mismatch in pair 0. busy for 1 cycle, done in the cycle after edge 1, aeqb=0, mismatch_idx=0.
3. a=8'h25, b=8'hA5 → mismatch in pair 3. done in the cycle after edge 4, aeqb=0, mismatch_idx=3.
4. Start with a=b=8'h00, then pulse start again with a=8'hFF, b=8'h00 during RUN and during DONE → both pulses ignored; aeqb=1 and mismatch_idx=0 held. A start one cycle after DONE is accepted and yields aeqb=0, mismatch_idx=0.
5. Start a=8'h3C, b=8'h3C; assert reset after edge 2 → busy=0 and done=0 immediately, and no done pulse ever appears. After reset release, a new compare of a=8'h3C, b=8'h7C gives aeqb=0, mismatch_idx=3.
6. Change a and b every cycle during RUN → result depends only on the values captured at the start edge (e.g. captured 8'h81 vs 8'h81 → aeqb=1).
